// File: rtl/ddr3_line_reader_if.sv
// ddr3_line_reader_if
//   Bundles the line-request handshake, the Avalon-MM read command/response
//   signals and the assembled-line output of ddr3_line_reader.
//   Modports:
//     master : client + memory side (drives requests, Avalon ready/read data)
//     slave  : the line reader itself
//   Signals:
//     rd_valid/rd_ready/rd_addr/rd_tag      line request handshake
//     ddr3_avl_*                            Avalon-MM read command / data
//     line_valid/line_data/line_tag         assembled line delivery
//     ddr3_rd_err                           sticky protocol error
interface ddr3_line_reader_if #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 26,
    parameter int LINE_BEATS = 8,
    parameter int BURST_LEN  = 4,
    parameter int RD_ADDR_W  = 10,
    parameter int TAG_W      = 4
);
    localparam int SIZE_W = $clog2(BURST_LEN) + 1;
    localparam int LINE_W = LINE_BEATS * DATA_W;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [RD_ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]     rd_tag;

    logic                 ddr3_avl_ready;
    logic                 ddr3_avl_read_req;
    logic                 ddr3_avl_burstbegin;
    logic [ADDR_W-1:0]    ddr3_avl_addr;
    logic [SIZE_W-1:0]    ddr3_avl_size;
    logic [DATA_W-1:0]    ddr3_avl_rdata;
    logic                 ddr3_avl_rdata_valid;

    logic                 line_valid;
    logic [LINE_W-1:0]    line_data;
    logic [TAG_W-1:0]     line_tag;
    logic                 ddr3_rd_err;

    modport master (
        output rd_valid, rd_addr, rd_tag,
        output ddr3_avl_ready, ddr3_avl_rdata, ddr3_avl_rdata_valid,
        input  rd_ready,
        input  ddr3_avl_read_req, ddr3_avl_burstbegin, ddr3_avl_addr, ddr3_avl_size,
        input  line_valid, line_data, line_tag, ddr3_rd_err
    );

    modport slave (
        input  rd_valid, rd_addr, rd_tag,
        input  ddr3_avl_ready, ddr3_avl_rdata, ddr3_avl_rdata_valid,
        output rd_ready,
        output ddr3_avl_read_req, ddr3_avl_burstbegin, ddr3_avl_addr, ddr3_avl_size,
        output line_valid, line_data, line_tag, ddr3_rd_err
    );
endinterface

// File: rtl/ddr3_line_reader.sv
// ddr3_line_reader
//   Fetches one wide line from DDR3 through the Avalon-MM read port. A line
//   request is split into LINE_BEATS/BURST_LEN burst read commands; returned
//   DATA_W-bit beats are assembled into a LINE_BEATS*DATA_W-bit line which is
//   delivered with a one-cycle line_valid strobe and the request tag.
//   Ports:
//     ddr3_clk  clock, all logic on the rising edge
//     reset_n   asynchronous, active-low reset
//     bus       ddr3_line_reader_if.slave (request, Avalon read, line output)
//   Build option:
//     DDR3_LINE_READER_ERR_EN  when defined, ddr3_rd_err latches any read beat
//                              that arrives while no line is outstanding;
//                              otherwise ddr3_rd_err is tied low.
module ddr3_line_reader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 26,
    parameter int LINE_BEATS = 8,
    parameter int BURST_LEN  = 4,
    parameter int RD_ADDR_W  = 10,
    parameter int TAG_W      = 4
) (
    input  logic             ddr3_clk,
    input  logic             reset_n,
    ddr3_line_reader_if.slave bus
);
    localparam int NBURST = LINE_BEATS / BURST_LEN;
    localparam int OFS_W  = $clog2(LINE_BEATS);
    localparam int BEAT_W = (LINE_BEATS > 1) ? OFS_W : 1;
    localparam int BCNT_W = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int SIZE_W = $clog2(BURST_LEN) + 1;
    localparam int LINE_W = LINE_BEATS * DATA_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD       = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t              state;
    logic                armed;      // low until the first clock after reset release
    logic [BCNT_W-1:0]   burst_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [TAG_W-1:0]    tag_q;

    logic                read_req;
    logic                burstbegin;
    logic [ADDR_W-1:0]   avl_addr;
    logic                line_valid;
    logic [LINE_W-1:0]   line_data;
    logic [TAG_W-1:0]    line_tag;

    logic                beat_take;
    logic                last_beat;
    logic                cmd_accept;
    logic                last_burst;

    // Beats only count while a line is outstanding; the counter is decoupled
    // from command issue so data may overtake later, still-stalled commands.
    assign beat_take  = bus.ddr3_avl_rdata_valid && (state != IDLE);
    assign last_beat  = (beat_cnt == BEAT_W'(LINE_BEATS - 1));
    assign cmd_accept = (state == CMD) && read_req && bus.ddr3_avl_ready;
    assign last_burst = (burst_cnt == BCNT_W'(NBURST - 1));

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            tag_q      <= '0;
            read_req   <= 1'b0;
            burstbegin <= 1'b0;
            avl_addr   <= '0;
            line_valid <= 1'b0;
            line_data  <= '0;
            line_tag   <= '0;
        end else begin
            armed      <= 1'b1;
            line_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rd_valid && armed) begin
                        tag_q      <= bus.rd_tag;
                        avl_addr   <= ADDR_W'(bus.rd_addr) << OFS_W;
                        burst_cnt  <= '0;
                        read_req   <= 1'b1;
                        burstbegin <= 1'b1;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_accept) begin
                        if (last_burst) begin
                            read_req   <= 1'b0;
                            burstbegin <= 1'b0;
                            state      <= WAIT_DATA;
                        end else begin
                            avl_addr  <= avl_addr + ADDR_W'(BURST_LEN);
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (beat_take) begin
                line_data[beat_cnt*DATA_W +: DATA_W] <= bus.ddr3_avl_rdata;
                // The previous line stays visible until the new line's first beat lands.
                if (beat_cnt == '0) begin
                    line_tag <= tag_q;
                end
                if (last_beat) begin
                    beat_cnt   <= '0;
                    line_valid <= 1'b1;
                    read_req   <= 1'b0;
                    burstbegin <= 1'b0;
                    state      <= IDLE;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.rd_ready            = (state == IDLE) && armed;
    assign bus.ddr3_avl_read_req   = read_req;
    assign bus.ddr3_avl_burstbegin = burstbegin;
    assign bus.ddr3_avl_addr       = avl_addr;
    assign bus.ddr3_avl_size       = SIZE_W'(BURST_LEN);
    assign bus.line_valid          = line_valid;
    assign bus.line_data           = line_data;
    assign bus.line_tag            = line_tag;

`ifdef DDR3_LINE_READER_ERR_EN
    logic rd_err;

    // A beat with no outstanding line means the controller returned data we
    // never asked for; remember it until reset.
    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_err <= 1'b0;
        end else if (bus.ddr3_avl_rdata_valid && (state == IDLE)) begin
            rd_err <= 1'b1;
        end
    end

    assign bus.ddr3_rd_err = rd_err;
`else
    assign bus.ddr3_rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_line_reader.sv
// tb_ddr3_line_reader
//   Directed + randomized bench for ddr3_line_reader with default parameters.
//   A memory model returns beat data derived from the word address; the
//   expected line, command addresses and strobe timing are computed from the
//   request alone and compared against what the DUT produces.
module tb_ddr3_line_reader;
    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 26;
    localparam int LINE_BEATS = 8;
    localparam int BURST_LEN  = 4;
    localparam int RD_ADDR_W  = 10;
    localparam int TAG_W      = 4;
    localparam int NBURST     = LINE_BEATS / BURST_LEN;
    localparam int LINE_W     = LINE_BEATS * DATA_W;

`ifdef DDR3_LINE_READER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    ddr3_line_reader_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_BEATS(LINE_BEATS),
        .BURST_LEN(BURST_LEN), .RD_ADDR_W(RD_ADDR_W), .TAG_W(TAG_W)
    ) bus ();

    ddr3_line_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_BEATS(LINE_BEATS),
        .BURST_LEN(BURST_LEN), .RD_ADDR_W(RD_ADDR_W), .TAG_W(TAG_W)
    ) dut (
        .ddr3_clk(clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Bus observation log, sampled mid-cycle.
    logic [ADDR_W-1:0] acc_addr_q[$];
    int                acc_cyc_q[$];
    int                req_cycles = 0;
    int                bb_bad     = 0;
    int                line_cnt   = 0;
    int                lv_cyc     = -1;
    logic              lv_ready;
    logic [LINE_W-1:0] lv_data;
    logic [TAG_W-1:0]  lv_tag;

    logic [LINE_W-1:0] prev_line = '0;
    logic [TAG_W-1:0]  prev_tag  = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ddr3_avl_read_req) req_cycles++;
            if (bus.ddr3_avl_burstbegin !== bus.ddr3_avl_read_req) bb_bad++;
            if (bus.ddr3_avl_read_req && bus.ddr3_avl_ready) begin
                acc_addr_q.push_back(bus.ddr3_avl_addr);
                acc_cyc_q.push_back(cyc_n);
            end
            if (bus.line_valid) begin
                line_cnt++;
                lv_cyc   = cyc_n;
                lv_ready = bus.rd_ready;
                lv_data  = bus.line_data;
                lv_tag   = bus.line_tag;
            end
        end
    end

    task automatic chk_w(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Memory contents: either the beat index, or a salted pattern of the word address.
    function automatic logic [DATA_W-1:0] beat_val(input bit idx_mode, input int k,
                                                   input logic [ADDR_W-1:0] word, input logic [31:0] salt);
        if (idx_mode) return DATA_W'(k);
        return {salt, 32'(word), ~salt, 32'(word) ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [DATA_W-1:0] q_addr(input int idx);
        if (idx < acc_addr_q.size()) return DATA_W'(acc_addr_q[idx]);
        return {DATA_W{1'bx}};
    endfunction

    function automatic int q_cyc(input int idx);
        if (idx < acc_cyc_q.size()) return acc_cyc_q[idx];
        return -1000;
    endfunction

    // mode 0: ready always high; 1: random ready and beat gaps;
    // 2: ready low for 'stall' cycles on the first command;
    // 3: second command stalled until beats 0..BURST_LEN-1 have returned.
    task automatic run_line(input logic [RD_ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                            input int mode, input int stall, input bit idx_mode);
        logic [ADDR_W-1:0] base;
        logic [31:0]       salt;
        logic [LINE_W-1:0] exp_line;
        int acc0, lines0, reqs0, sent, cyc, req_cyc, beat_cyc, accepted;

        base = ADDR_W'(a) * ADDR_W'(LINE_BEATS);
        salt = $urandom;
        for (int k = 0; k < LINE_BEATS; k++)
            exp_line[k*DATA_W +: DATA_W] = beat_val(idx_mode, k, base + ADDR_W'(k), salt);
        acc0   = acc_addr_q.size();
        lines0 = line_cnt;
        reqs0  = req_cycles;

        chk_w("rd_ready_idle", DATA_W'(bus.rd_ready), DATA_W'(1));
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        bus.rd_tag   = t;
        req_cyc      = cyc_n;
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = RD_ADDR_W'($urandom);
        bus.rd_tag   = TAG_W'($urandom);
        chk_w("rd_ready_busy", DATA_W'(bus.rd_ready), DATA_W'(0));
        chk_w("tag_hold", DATA_W'(bus.line_tag), DATA_W'(prev_tag));

        sent = 0; cyc = 0; beat_cyc = -1;
        while (line_cnt == lines0 && cyc < 300) begin
            accepted = acc_addr_q.size() - acc0;
            case (mode)
                1:       bus.ddr3_avl_ready = 1'($urandom_range(0, 1));
                2:       bus.ddr3_avl_ready = !(accepted == 0 && cyc < stall);
                3:       bus.ddr3_avl_ready = !(accepted == 1 && sent < BURST_LEN);
                default: bus.ddr3_avl_ready = 1'b1;
            endcase
            if (sent < LINE_BEATS && sent < accepted * BURST_LEN &&
                (mode != 1 || $urandom_range(0, 3) != 0)) begin
                bus.ddr3_avl_rdata_valid = 1'b1;
                bus.ddr3_avl_rdata       = beat_val(idx_mode, sent, base + ADDR_W'(sent), salt);
                if (sent == LINE_BEATS - 1) beat_cyc = cyc_n;
                sent++;
            end else begin
                bus.ddr3_avl_rdata_valid = 1'b0;
                bus.ddr3_avl_rdata       = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.ddr3_avl_rdata_valid = 1'b0;
        bus.ddr3_avl_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk_i("line_count", line_cnt - lines0, 1);
        chk_i("lv_latency", lv_cyc, beat_cyc + 1);
        chk_w("lv_rd_ready", DATA_W'(lv_ready), DATA_W'(1));
        chk_i("cmd_count", acc_addr_q.size() - acc0, NBURST);
        for (int b = 0; b < NBURST; b++)
            chk_w($sformatf("cmd_addr%0d", b), q_addr(acc0 + b),
                  DATA_W'(base + ADDR_W'(b * BURST_LEN)));
        if (mode == 0 || mode == 2) begin
            chk_i("cmd_first_cyc", q_cyc(acc0), req_cyc + 1 + ((mode == 2) ? stall : 0));
            chk_i("cmd_b2b", q_cyc(acc0 + 1) - q_cyc(acc0), 1);
            chk_i("req_cycles", req_cycles - reqs0, NBURST + ((mode == 2) ? stall : 0));
        end
        for (int k = 0; k < LINE_BEATS; k++)
            chk_w($sformatf("line_slice%0d", k), lv_data[k*DATA_W +: DATA_W], exp_line[k*DATA_W +: DATA_W]);
        chk_w("line_tag", DATA_W'(lv_tag), DATA_W'(t));
        chk_w("line_data_hold", bus.line_data[(LINE_BEATS-1)*DATA_W +: DATA_W],
              exp_line[(LINE_BEATS-1)*DATA_W +: DATA_W]);
        prev_line = exp_line;
        prev_tag  = t;
    endtask

    initial begin
        int sent, cyc, lines_before, accepted;

        reset_n                  = 1'b0;
        bus.rd_valid             = 1'b0;
        bus.rd_addr              = '0;
        bus.rd_tag               = '0;
        bus.ddr3_avl_ready       = 1'b1;
        bus.ddr3_avl_rdata       = '0;
        bus.ddr3_avl_rdata_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_w("rst_read_req", DATA_W'(bus.ddr3_avl_read_req), DATA_W'(0));
        chk_w("rst_burstbegin", DATA_W'(bus.ddr3_avl_burstbegin), DATA_W'(0));
        chk_w("rst_addr", DATA_W'(bus.ddr3_avl_addr), DATA_W'(0));
        chk_w("rst_line_valid", DATA_W'(bus.line_valid), DATA_W'(0));
        chk_w("rst_line_tag", DATA_W'(bus.line_tag), DATA_W'(0));
        chk_w("rst_line_data", DATA_W'(|bus.line_data), DATA_W'(0));
        chk_w("rst_err", DATA_W'(bus.ddr3_rd_err), DATA_W'(0));
        chk_w("avl_size", DATA_W'(bus.ddr3_avl_size), DATA_W'(BURST_LEN));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic line, beat k carries k
        run_line(10'h005, 4'd3, 0, 0, 1'b1);
        // First command stalled three cycles
        run_line(10'h005, 4'd9, 2, 3, 1'b0);
        // Data for the first burst returns while the second command waits
        run_line(10'($urandom), 4'd12, 3, 0, 1'b0);
        // Top line index, no address wrap
        run_line(10'h3FF, 4'd7, 0, 0, 1'b0);

        // Stray beat while idle
        lines_before = line_cnt;
        bus.ddr3_avl_rdata_valid = 1'b1;
        bus.ddr3_avl_rdata       = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.ddr3_avl_rdata_valid = 1'b0;
        @(posedge clk); #1;
        chk_i("idle_no_lv", line_cnt - lines_before, 0);
        for (int k = 0; k < LINE_BEATS; k++)
            chk_w($sformatf("idle_slice%0d", k), bus.line_data[k*DATA_W +: DATA_W], prev_line[k*DATA_W +: DATA_W]);
        chk_w("idle_err", DATA_W'(bus.ddr3_rd_err), DATA_W'(ERR_EN));

        // Reset in the middle of a line, after five beats
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 10'h123;
        bus.rd_tag   = 4'd6;
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 5 && cyc < 50) begin
            accepted = acc_addr_q.size();
            if (sent < 4 || accepted >= 2 + 0) begin
                bus.ddr3_avl_rdata_valid = 1'b1;
                bus.ddr3_avl_rdata       = {$urandom, $urandom, $urandom, $urandom};
                sent++;
            end else begin
                bus.ddr3_avl_rdata_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.ddr3_avl_rdata_valid = 1'b0;
        chk_i("abort_beats_sent", sent, 5);
        reset_n = 1'b0;
        #1;
        chk_w("mid_rst_read_req", DATA_W'(bus.ddr3_avl_read_req), DATA_W'(0));
        chk_w("mid_rst_burstbegin", DATA_W'(bus.ddr3_avl_burstbegin), DATA_W'(0));
        chk_w("mid_rst_addr", DATA_W'(bus.ddr3_avl_addr), DATA_W'(0));
        chk_w("mid_rst_line_valid", DATA_W'(bus.line_valid), DATA_W'(0));
        chk_w("mid_rst_line_tag", DATA_W'(bus.line_tag), DATA_W'(0));
        chk_w("mid_rst_line_data", DATA_W'(|bus.line_data), DATA_W'(0));
        chk_w("mid_rst_err", DATA_W'(bus.ddr3_rd_err), DATA_W'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        prev_line = '0;
        prev_tag  = '0;

        // Leftover beat after release is dropped
        lines_before = line_cnt;
        bus.ddr3_avl_rdata_valid = 1'b1;
        bus.ddr3_avl_rdata       = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.ddr3_avl_rdata_valid = 1'b0;
        @(posedge clk); #1;
        chk_i("post_rst_no_lv", line_cnt - lines_before, 0);
        chk_w("post_rst_line_data", DATA_W'(|bus.line_data), DATA_W'(0));
        chk_w("post_rst_err", DATA_W'(bus.ddr3_rd_err), DATA_W'(ERR_EN));

        // Complete line after the aborted one
        run_line(10'h0A6, 4'd1, 0, 0, 1'b0);

        // Randomized lines
        for (int i = 0; i < 6; i++)
            run_line(RD_ADDR_W'($urandom), TAG_W'($urandom), 1, 0, 1'b0);

        chk_i("burstbegin_tracks_read", bb_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
